branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry direction state, misprediction detection and event counters.
// Define BP_BHT_EN for 2-bit saturating direction counters; the default build keeps a 1-bit last-outcome state.
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int PC_W    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_all,
   input  logic            lookup_en,
   input  logic [PC_W-1:0] pcf,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_is_br,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [PC_W-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     cnt_hits,
   output logic [31:0]     cnt_mispred
);

   localparam int IW = $clog2(ENTRIES);
   localparam int TW = PC_W - IW - 2;

`ifdef BP_BHT_EN
   localparam int SW = 2;
   localparam logic [SW-1:0] ALLOC_STATE = 2'b10;
`else
   localparam int SW = 1;
   localparam logic [SW-1:0] ALLOC_STATE = 1'b1;
`endif

   logic [ENTRIES-1:0] valid_q;
   logic [TW-1:0]      tag_q    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
   logic [SW-1:0]      state_q  [ENTRIES];

   logic [IW-1:0] idx_f;
   logic [IW-1:0] idx_u;
   logic [TW-1:0] tag_f;
   logic [TW-1:0] tag_u;
   logic          hit_f;
   logic          hit_u;
   logic [SW-1:0] state_next;
   logic          do_update;
   logic          alloc;
   logic          train;
   logic          kill;
   logic          unused_pc_bits;

   assign idx_f = pcf[IW+1:2];
   assign tag_f = pcf[PC_W-1:IW+2];
   assign idx_u = upd_pc[IW+1:2];
   assign tag_u = upd_pc[PC_W-1:IW+2];

   // The two instruction-alignment bits never take part in indexing or tagging.
   assign unused_pc_bits = ^{pcf[1:0], upd_pc[1:0]};

   assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign hit_u       = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
   assign pred_taken  = hit_f && state_q[idx_f][SW-1];
   assign pred_target = pred_taken ? target_q[idx_f] : pcf + PC_W'(4);

   assign mispredict  = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

   // A flush suppresses any update resolving in the same cycle.
   assign do_update = upd_valid && !flush_all;
   assign alloc     = do_update && upd_is_br && !hit_u && upd_taken;
   assign train     = do_update && upd_is_br && hit_u;
   assign kill      = do_update && !upd_is_br && hit_u;

   always_comb begin
      state_next = state_q[idx_u];
`ifdef BP_BHT_EN
      if (upd_taken) begin
         if (state_next != 2'b11) state_next = state_next + 2'd1;
      end else begin
         if (state_next != 2'b00) state_next = state_next - 2'd1;
      end
`else
      state_next = upd_taken;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         cnt_hits    <= '0;
         cnt_mispred <= '0;
         for (int i = 0; i < ENTRIES; i++) state_q[i] <= '0;
      end else begin
         if (lookup_en && hit_f) cnt_hits <= cnt_hits + 32'd1;
         if (mispredict) cnt_mispred <= cnt_mispred + 32'd1;
         if (flush_all) begin
            valid_q <= '0;
         end else if (alloc) begin
            valid_q[idx_u] <= 1'b1;
            state_q[idx_u] <= ALLOC_STATE;
         end else if (train) begin
            state_q[idx_u] <= state_next;
         end else if (kill) begin
            valid_q[idx_u] <= 1'b0;
         end
      end
   end

   // Tag and target storage needs no reset since the valid bits guard it.
   always_ff @(posedge clk) begin
      if (rst_n && (alloc || (train && upd_taken))) begin
         target_q[idx_u] <= upd_target;
      end
      if (rst_n && alloc) begin
         tag_q[idx_u] <= tag_u;
      end
   end

endmodule
